// File: rtl/l2_bank_pkg.sv
// rtl/l2_bank_pkg.sv - shared types and constants for the L2 bank TCDM adapter
//   bank_state_e    : bank controller state (INIT zero-fill, RUN serving requests)
//   resp_meta_t     : per-grant response metadata carried down the response pipe
//   TCDM_DATA_WIDTH : TCDM / SRAM data width in bits
package l2_bank_pkg;

    localparam int unsigned TCDM_DATA_WIDTH = 32;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } bank_state_e;

    typedef struct packed {
        logic valid;
        logic is_read;
        logic err;
    } resp_meta_t;

endpackage

// File: rtl/l2_bank_resp_pipe.sv
// rtl/l2_bank_resp_pipe.sv - fixed-depth delay line of response metadata
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears every stage)
//   meta_i        : metadata of the request granted this cycle
//   meta_o        : metadata of the request granted DEPTH cycles ago
module l2_bank_resp_pipe
    import l2_bank_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  resp_meta_t meta_i,
    output resp_meta_t meta_o
);

    resp_meta_t r_stage [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= meta_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign meta_o = r_stage[DEPTH-1];

endmodule

// File: rtl/l2_bank_tcdm_adapter.sv
// rtl/l2_bank_tcdm_adapter.sv - TCDM slave port to single-ported SRAM bank adapter
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   req_i/add_i/wen_i/be_i/wdata_i/gnt_o : TCDM request channel (wen_i=1 is read)
//   r_valid_o/r_rdata_o/r_opc_o          : fixed-latency response (opc=1 out of range)
//   mem_req_o/mem_we_o/mem_addr_o/mem_be_o/mem_wdata_o/mem_rdata_i : SRAM macro port
//   init_done_o              : high once the post-reset zero-fill has finished
module l2_bank_tcdm_adapter
    import l2_bank_pkg::*;
#(
    parameter int unsigned BANK_WORDS     = 4096,
    parameter int unsigned PORT_SEL_WIDTH = 2,
    parameter int unsigned SRAM_LATENCY   = 1,
    parameter bit          INIT_ON_RESET  = 1'b1,
    localparam int unsigned AW            = $clog2(BANK_WORDS)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_i,
    input  logic [31:0]                add_i,
    input  logic                       wen_i,
    input  logic [3:0]                 be_i,
    input  logic [TCDM_DATA_WIDTH-1:0] wdata_i,
    output logic                       gnt_o,
    output logic                       r_valid_o,
    output logic [TCDM_DATA_WIDTH-1:0] r_rdata_o,
    output logic                       r_opc_o,
    output logic                       mem_req_o,
    output logic                       mem_we_o,
    output logic [AW-1:0]              mem_addr_o,
    output logic [3:0]                 mem_be_o,
    output logic [TCDM_DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [TCDM_DATA_WIDTH-1:0] mem_rdata_i,
    output logic                       init_done_o
);

    bank_state_e r_state;
    logic [AW-1:0] r_cnt;

    logic [31:0] w_waddr;
    logic        w_in_range;
    logic        w_run;
    logic        w_init;
    resp_meta_t  w_meta_in;
    resp_meta_t  w_meta_out;

    // Interleave bits sit just above the byte offset; drop both.
    assign w_waddr    = add_i >> (2 + PORT_SEL_WIDTH);
    assign w_in_range = (w_waddr < 32'(BANK_WORDS));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= INIT_ON_RESET ? INIT : RUN;
            r_cnt   <= '0;
        end else if (r_state == INIT) begin
            if (r_cnt == AW'(BANK_WORDS - 1)) begin
                r_state <= RUN;
            end
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Qualify with rst_ni so every output holds its idle value while reset is
    // asserted, even when the state register resets straight into RUN.
    assign w_run  = rst_ni && (r_state == RUN);
    assign w_init = rst_ni && (r_state == INIT);

    assign gnt_o       = w_run && req_i;
    assign init_done_o = w_run;

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (w_init) begin
            mem_req_o  = 1'b1;
            mem_we_o   = 1'b1;
            mem_addr_o = r_cnt;
            mem_be_o   = 4'hF;
        end else if (w_run) begin
            mem_req_o   = req_i && w_in_range;
            mem_we_o    = !wen_i;
            mem_addr_o  = w_waddr[AW-1:0];
            mem_be_o    = be_i;
            mem_wdata_o = wdata_i;
        end
    end

    assign w_meta_in = '{valid: gnt_o, is_read: wen_i, err: !w_in_range};

    l2_bank_resp_pipe #(
        .DEPTH (SRAM_LATENCY)
    ) u_resp_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .meta_i (w_meta_in),
        .meta_o (w_meta_out)
    );

    // Last stage lines up with the SRAM data, so no output register is needed.
    assign r_valid_o = w_meta_out.valid;
    assign r_opc_o   = w_meta_out.valid && w_meta_out.err;
    assign r_rdata_o = (w_meta_out.valid && w_meta_out.is_read && !w_meta_out.err)
                       ? mem_rdata_i : '0;

endmodule

// File: tb/tb_l2_bank_tcdm_adapter.sv
// tb/tb_l2_bank_tcdm_adapter.sv - self-checking bench for l2_bank_tcdm_adapter
module tb_l2_bank_tcdm_adapter;

    localparam int WORDS = 16;
    localparam int LAT   = 3;
    localparam int NBANK = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [31:0] add = '0;
    logic        wen = 1'b1;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        gnt_o, r_valid_o, r_opc_o, mem_req_o, mem_we_o, init_done_o;
    logic [31:0] r_rdata_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_addr_o, mem_be_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    l2_bank_tcdm_adapter #(
        .BANK_WORDS     (WORDS),
        .PORT_SEL_WIDTH (2),
        .SRAM_LATENCY   (LAT),
        .INIT_ON_RESET  (1'b1)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .add_i       (add),
        .wen_i       (wen),
        .be_i        (be),
        .wdata_i     (wdata),
        .gnt_o       (gnt_o),
        .r_valid_o   (r_valid_o),
        .r_rdata_o   (r_rdata_o),
        .r_opc_o     (r_opc_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_be_o    (mem_be_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .init_done_o (init_done_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] en);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (en[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // SRAM macro: read data valid LAT cycles after the access.
    logic [31:0] sram [WORDS];
    logic [31:0] rd_pipe [LAT];
    always @(posedge clk) begin
        if (mem_req_o) begin
            if (mem_we_o) sram[mem_addr_o] <= merge(sram[mem_addr_o], mem_wdata_o, mem_be_o);
            else          rd_pipe[0] <= sram[mem_addr_o];
        end
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata_i = rd_pipe[LAT-1];

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Reference model: shadow of bank contents plus a queue of due responses.
    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        opc;
    } resp_t;
    resp_t       expq[$];
    logic [31:0] shadow [WORDS];

    always @(negedge clk) begin
        int  wa;
        bit  inr;
        bit  run;
        if (!rst_n) begin
            expq.delete();
            for (int i = 0; i < WORDS; i++) shadow[i] = '0;
            chk("rst_gnt", 32'(gnt_o), 0);
            chk("rst_valid", 32'(r_valid_o), 0);
            chk("rst_rdata", r_rdata_o, 0);
            chk("rst_opc", 32'(r_opc_o), 0);
            chk("rst_mem_req", 32'(mem_req_o), 0);
            chk("rst_init_done", 32'(init_done_o), 0);
        end else begin
            wa  = int'(add / (4 * NBANK));
            inr = (add / (4 * NBANK)) < WORDS;
            run = (cyc >= WORDS);
            chk("init_done", 32'(init_done_o), 32'(run));
            chk("gnt", 32'(gnt_o), 32'(req && run));
            if (!run) begin
                chk("init_req", 32'(mem_req_o), 1);
                chk("init_we", 32'(mem_we_o), 1);
                chk("init_addr", 32'(mem_addr_o), 32'(cyc));
                chk("init_be", 32'(mem_be_o), 32'hF);
                chk("init_wdata", mem_wdata_o, 0);
            end else begin
                chk("mem_req", 32'(mem_req_o), 32'(req && inr));
                if (req && inr) begin
                    chk("mem_addr", 32'(mem_addr_o), 32'(wa));
                    chk("mem_we", 32'(mem_we_o), 32'(!wen));
                    if (!wen) begin
                        chk("mem_be", 32'(mem_be_o), 32'(be));
                        chk("mem_wdata", mem_wdata_o, wdata);
                    end
                end
            end
            if (r_valid_o) begin
                if (expq.size() == 0 || expq[0].due != cyc) begin
                    chk("resp_unexpected", 32'(r_valid_o), 0);
                end else begin
                    chk("resp_rdata", r_rdata_o, expq[0].rdata);
                    chk("resp_opc", 32'(r_opc_o), 32'(expq[0].opc));
                    void'(expq.pop_front());
                end
            end else if (expq.size() > 0 && expq[0].due == cyc) begin
                chk("resp_missing", 32'(r_valid_o), 1);
                void'(expq.pop_front());
            end
            if (req && run) begin
                resp_t r;
                r.due   = cyc + LAT;
                r.opc   = !inr;
                r.rdata = (inr && wen) ? shadow[wa] : 32'h0;
                if (inr && !wen) shadow[wa] = merge(shadow[wa], wdata, be);
                expq.push_back(r);
            end
        end
    end

    typedef struct {
        logic [31:0] add;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        exp_mreq;
        logic [3:0]  exp_maddr;
        logic [31:0] exp_rdata;
        logic        exp_opc;
    } vec_t;
    vec_t tbl [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        tbl[0] = '{32'h40,       1'b0, 4'b0011, 32'hDEADBEEF, 1'b1, 4'd4,  32'h0,        1'b0};
        tbl[1] = '{32'h40,       1'b1, 4'b0000, 32'h0,        1'b1, 4'd4,  32'h0000BEEF, 1'b0};
        tbl[2] = '{32'h44,       1'b0, 4'b1100, 32'h12345678, 1'b1, 4'd4,  32'h0,        1'b0};
        tbl[3] = '{32'h48,       1'b1, 4'b0000, 32'h0,        1'b1, 4'd4,  32'h1234BEEF, 1'b0};
        tbl[4] = '{32'hF0,       1'b1, 4'b0000, 32'h0,        1'b1, 4'd15, 32'h0,        1'b0};
        tbl[5] = '{32'h100,      1'b1, 4'b0000, 32'h0,        1'b0, 4'd0,  32'h0,        1'b1};
        tbl[6] = '{32'hFFFFFFF0, 1'b0, 4'b1111, 32'hCAFEF00D, 1'b0, 4'd0,  32'h0,        1'b1};
        tbl[7] = '{32'hF0,       1'b0, 4'b1111, 32'hA5A5A5A5, 1'b1, 4'd15, 32'h0,        1'b0};
        tbl[8] = '{32'hFC,       1'b1, 4'b0000, 32'h0,        1'b1, 4'd15, 32'hA5A5A5A5, 1'b0};

        // Reset, with a read already pending that must stall through INIT.
        repeat (3) @(posedge clk);
        #1;
        req = 1'b1; wen = 1'b1; add = 32'h80;
        rst_n = 1'b1;
        w = 0;
        while (cyc != WORDS && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("init_stall_grant", 32'(gnt_o), 1);
        step();
        req = 1'b0;
        repeat (LAT + 1) step();

        // Directed table, one request at a time.
        for (int i = 0; i < 9; i++) begin
            req = 1'b1; add = tbl[i].add; wen = tbl[i].wen; be = tbl[i].be; wdata = tbl[i].wdata;
            @(negedge clk);
            chk($sformatf("tbl%0d_mem_req", i), 32'(mem_req_o), 32'(tbl[i].exp_mreq));
            if (tbl[i].exp_mreq) begin
                chk($sformatf("tbl%0d_mem_addr", i), 32'(mem_addr_o), 32'(tbl[i].exp_maddr));
                chk($sformatf("tbl%0d_mem_be", i), 32'(mem_be_o), 32'(tbl[i].wen ? mem_be_o : tbl[i].be));
            end
            repeat (LAT) begin
                step();
                req = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), 32'(r_valid_o), 1);
            chk($sformatf("tbl%0d_rdata", i), r_rdata_o, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_opc", i), 32'(r_opc_o), 32'(tbl[i].exp_opc));
            step();
        end

        // Fill words 0..7, then stream 8 back-to-back reads.
        for (int i = 0; i < 8; i++) begin
            req = 1'b1; wen = 1'b0; be = 4'hF; add = 32'(i << 4); wdata = 32'h10000000 + 32'(i);
            step();
        end
        for (int k = 0; k <= 8 + LAT; k++) begin
            if (k < 8) begin
                req = 1'b1; wen = 1'b1; add = 32'(k << 4);
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
            if (k >= LAT && k - LAT < 8) begin
                chk($sformatf("stream%0d_valid", k - LAT), 32'(r_valid_o), 1);
                chk($sformatf("stream%0d_rdata", k - LAT), r_rdata_o, 32'h10000000 + 32'(k - LAT));
            end else if (k == 8 + LAT) begin
                chk("stream_end_valid", 32'(r_valid_o), 0);
            end
            step();
        end

        // Random traffic, including out-of-range addresses.
        for (int i = 0; i < 300; i++) begin
            req   = ($urandom_range(0, 9) < 7);
            add   = 32'($urandom_range(0, 32'h13F));
            wen   = 1'($urandom_range(0, 1));
            be    = 4'($urandom_range(0, 15));
            wdata = $urandom;
            step();
        end
        req = 1'b0;
        repeat (LAT + 2) step();

        // Reset with two reads in flight.
        req = 1'b1; wen = 1'b1; add = 32'h10;
        step();
        add = 32'h20;
        step();
        req = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_addr", 32'(mem_addr_o), 0);
        chk("restart_req", 32'(mem_req_o), 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("no_valid_after_rst", 32'(r_valid_o), 0);
        end
        chk("queue_drained", 32'(expq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
